instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 181: number of instruction-memory words; legal write addresses are 0..IMEM_DEPTH-1.
REQ-002 Parameter ADDR_W, default 16: width of addr and of the word counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; ignored unless the block is idle or finished.
REQ-006 byte_valid  input  1  the byte source presents a byte on byte_in.
REQ-007 byte_in  input  8  program byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 write_en  output  1  write strobe to the instruction-memory write port.
REQ-010 addr  output  ADDR_W  instruction-memory word address.
REQ-011 instr_in  output  16  word to be written.
REQ-012 busy  output  1  high from accepted start until DONE or ERROR.
REQ-013 done  output  1  load completed; held until next accepted start.
REQ-014 error  output  1  length header exceeded IMEM_DEPTH; held until next accepted start.

Function
REQ-015 Byte handshake: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1.
REQ-016 byte_ready shall be 1 only in states LEN_HI, LEN_LO, DAT_HI, DAT_LO.
REQ-017 Stream format: 16-bit length N (high byte first), then N 16-bit words (high byte first).
REQ-018 States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start -> LEN_HI; clears done, error, word counter; sets busy.
REQ-020 LEN_HI -> LEN_LO on transfer; LEN_LO -> check on transfer.
REQ-021 Check: N=0 -> DONE; N>IMEM_DEPTH -> ERROR with no write; else -> DAT_HI.
REQ-022 DAT_HI -> DAT_LO on transfer (byte latched as instr_in[15:8]); DAT_LO -> WRITE on transfer (byte latched as instr_in[7:0]).
REQ-023 WRITE: write_en=1 for exactly one cycle, addr=word counter, instr_in=assembled word; counter increments at end of cycle.
REQ-024 After WRITE: counter=N -> DONE, else -> DAT_HI.
REQ-025 Latency: write_en asserts in the cycle after the low-byte transfer; one word per minimum 3 cycles.
REQ-026 write_en shall be 0 in every state except WRITE; addr and instr_in hold last values otherwise.
REQ-027 start while busy is ignored; byte_valid outside accepting states is ignored (no transfer).
REQ-028 byte_valid deasserting between bytes stalls the FSM indefinitely; no timeout.
REQ-029 Addresses never exceed IMEM_DEPTH-1; counter does not wrap.

Reset
REQ-030 rst_n=0 immediately forces IDLE, byte_ready=0, write_en=0, addr=0, instr_in=0, busy=0, done=0, error=0, counter=0.
REQ-031 Reset mid-load abandons the load; words already written stay in memory; no partial word is written.

Structure
REQ-032 Shared package holds IMEM_DEPTH, state encoding and opcode constants (e.g. ENDOP=51), common with the instruction memory and control unit.
REQ-033 Single module, no sub-module; byte-pair packing is inline.

Verification
REQ-034 start; bytes 00 02 | 00 26 | 01 01 -> writes addr0=0x0026, addr1=0x0101; done=1, busy=0.
REQ-035 Length 00 00 -> no write_en pulse; done=1 two cycles after LEN_LO transfer.
REQ-036 Length 00 B6 (182) -> error=1, no write_en; new start clears error.
REQ-037 Length 181 full program -> last write at addr 180, done=1, addr never 181.
REQ-038 byte_valid gapped 5 cycles between bytes, and start pulsed mid-load -> same writes as REQ-034, start ignored.
REQ-039 rst_n low after the high byte of word 1 -> outputs reset immediately; only addr0 written; restart loads correctly.

Source files
------------

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_loader_pkg : constants, loader states and opcodes shared with    |
// |                    the instruction memory and control unit.            |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package instr_loader_pkg;

  localparam int IMEM_DEPTH_DEF = 181;
  localparam int ADDR_W_DEF     = 16;
  localparam int WORD_W         = 16;
  localparam int BYTE_W         = 8;

  localparam logic [7:0] ENDOP = 8'd51;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_CHECK  = 4'd3,
    S_DAT_HI = 4'd4,
    S_DAT_LO = 4'd5,
    S_WRITE  = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  function automatic logic accepts_byte(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) || (s == S_DAT_LO);
  endfunction

  // States in which a new start request is honoured.
  function automatic logic is_settled(input state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_loader_if : byte-source handshake, memory write port and status. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic                start;
  logic                byte_valid;
  logic [BYTE_W-1:0]   byte_in;
  logic                byte_ready;
  logic                write_en;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   instr_in;
  logic                busy;
  logic                done;
  logic                error;

  modport master (
    input  start, byte_valid, byte_in,
    output byte_ready, write_en, addr, instr_in, busy, done, error
  );

  modport slave (
    output start, byte_valid, byte_in,
    input  byte_ready, write_en, addr, instr_in, busy, done, error
  );

endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_loader : loads a length-prefixed byte stream into instr memory.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  instr_loader_if.master bus
);

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_len;
  logic [BYTE_W-1:0]   r_hi;
  logic [WORD_W-1:0]   r_instr;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_inc;
  logic                w_xfer;
  logic                w_start_ok;

  assign w_xfer     = bus.byte_valid & accepts_byte(r_state);
  assign w_start_ok = bus.start & is_settled(r_state);
  assign w_cnt_inc  = r_cnt + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The length is registered before being checked, so DONE/ERROR
  // follow the low length byte by one extra cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_ok) w_next = S_LEN_HI;
      end
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = S_CHECK;
      S_CHECK: begin
        if (r_len == '0) begin
          w_next = S_DONE;
        end else if (32'(r_len) > 32'(IMEM_DEPTH)) begin
          w_next = S_ERROR;
        end else begin
          w_next = S_DAT_HI;
        end
      end
      S_DAT_HI: if (w_xfer) w_next = S_DAT_LO;
      S_DAT_LO: if (w_xfer) w_next = S_WRITE;
      S_WRITE: begin
        if (32'(w_cnt_inc) == 32'(r_len)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DAT_HI;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_hi    <= '0;
      r_instr <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_start_ok) begin
        r_cnt <= '0;
      end
      if (w_xfer && r_state == S_LEN_HI) begin
        r_len[15:8] <= bus.byte_in;
      end
      if (w_xfer && r_state == S_LEN_LO) begin
        r_len[7:0] <= bus.byte_in;
      end
      if (w_xfer && r_state == S_DAT_HI) begin
        r_hi <= bus.byte_in;
      end
      // Word and address update together so both hold steady outside WRITE.
      if (w_xfer && r_state == S_DAT_LO) begin
        r_instr <= {r_hi, bus.byte_in};
        r_addr  <= r_cnt;
      end
      if (r_state == S_WRITE) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.byte_ready = accepts_byte(r_state);
  assign bus.write_en   = (r_state == S_WRITE);
  assign bus.addr       = r_addr;
  assign bus.instr_in   = r_instr;
  assign bus.busy       = ~is_settled(r_state);
  assign bus.done       = (r_state == S_DONE);
  assign bus.error      = (r_state == S_ERROR);

endmodule
`default_nettype wire
